// File: rtl/mix_pkg.sv
// Shared MIX word layout, CHAR digit constants and sign-magnitude helpers.
package mix_pkg;

  localparam int unsigned WORD_W    = 31;
  localparam int unsigned MAG_W     = 30;
  localparam int unsigned SIGN_BIT  = 30;
  localparam int unsigned ZERO_CODE = 30;
  localparam int unsigned DIGITS    = 10;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned CODE_W    = 6;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic {
    CV_IDLE,
    CV_RUN
  } cv_state_e;

  function automatic logic sign(input logic [WORD_W-1:0] w);
    return w[SIGN_BIT];
  endfunction

  function automatic logic [MAG_W-1:0] mag(input logic [WORD_W-1:0] w);
    return w[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/mix_bin2char.sv
// Sequential double-dabble converter: 30-bit magnitude to ten MIX digit codes,
// one input bit per clock.
module mix_bin2char
  import mix_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [MAG_W-1:0]         bin_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CODE_W*DIGITS-1:0] codes_o
);

  cv_state_e                 state_q;
  logic [MAG_W-1:0]          bin_q;
  logic [BCD_W-1:0]          bcd_q;
  logic [BCD_W-1:0]          bcd_adj;
  logic [BCD_W-1:0]          bcd_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      done_q;
  logic [CODE_W*DIGITS-1:0]  codes_q;
  logic [CODE_W*DIGITS-1:0]  codes_d;

  // Add-3 correction on every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCD_W-2:0], bin_q[MAG_W-1]};
    codes_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      codes_d[CODE_W*i +: CODE_W] = CODE_W'(ZERO_CODE) + {2'b00, bcd_d[4*i +: 4]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      codes_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CV_IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CV_RUN;
          end
        end
        CV_RUN: begin
          bin_q <= {bin_q[MAG_W-2:0], 1'b0};
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Final iteration publishes its own result directly, so done lands one cycle later.
          if (cnt_q == CNT_W'(MAG_W - 1)) begin
            state_q <= CV_IDLE;
            done_q  <= 1'b1;
            codes_q <= codes_d;
          end
        end
        default: state_q <= CV_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == CV_RUN);
  assign done_o  = done_q;
  assign codes_o = codes_q;

endmodule

// File: rtl/mix_add_char_unit.sv
// MIX execution unit: sign-magnitude ADD with overflow and the CHAR
// binary-to-character conversion, operating independently.
module mix_add_char_unit
  import mix_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     add_start,
  input  logic [WORD_W-1:0]        add_in1,
  input  logic [WORD_W-1:0]        add_in2,
  output logic                     add_done,
  output logic [WORD_W-1:0]        add_out,
  output logic                     add_ovf,
  input  logic                     char_start,
  input  logic [MAG_W-1:0]         char_in,
  output logic                     char_busy,
  output logic                     char_done,
  output logic [CODE_W*DIGITS-1:0] char_out
);

  logic             add_done_q;
  logic             s1, s2;
  logic [MAG_W-1:0] m1, m2;
  logic [MAG_W:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) add_done_q <= 1'b0;
    else       add_done_q <= add_start;
  end

  // Operands arrive in the done cycle, so the result is purely combinational.
  always_comb begin
    s1      = sign(add_in1);
    s2      = sign(add_in2);
    m1      = mag(add_in1);
    m2      = mag(add_in2);
    sum     = {1'b0, m1} + {1'b0, m2};
    add_ovf = 1'b0;
    if (s1 == s2) begin
      add_out = {s1, sum[MAG_W-1:0]};
      add_ovf = sum[MAG_W];
    end else if (m1 >= m2) begin
      add_out = {s1, m1 - m2};
    end else begin
      add_out = {s2, m2 - m1};
    end
  end

  assign add_done = add_done_q;

  mix_bin2char u_bin2char (
    .clk     (clk),
    .reset   (reset),
    .start_i (char_start),
    .bin_i   (char_in),
    .busy_o  (char_busy),
    .done_o  (char_done),
    .codes_o (char_out)
  );

endmodule

// File: tb/tb_mix_add_char_unit.sv
// Directed self-checking bench for mix_add_char_unit.
module tb_mix_add_char_unit;

  logic        clk;
  logic        reset;
  logic        add_start;
  logic [30:0] add_in1;
  logic [30:0] add_in2;
  logic        add_done;
  logic [30:0] add_out;
  logic        add_ovf;
  logic        char_start;
  logic [29:0] char_in;
  logic        char_busy;
  logic        char_done;
  logic [59:0] char_out;

  int checks = 0;
  int errors = 0;
  int n;
  int extra;

  mix_add_char_unit dut (
    .clk        (clk),
    .reset      (reset),
    .add_start  (add_start),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_done   (add_done),
    .add_out    (add_out),
    .add_ovf    (add_ovf),
    .char_start (char_start),
    .char_in    (char_in),
    .char_busy  (char_busy),
    .char_done  (char_done),
    .char_out   (char_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] sm(input logic s, input logic [29:0] m);
    return {s, m};
  endfunction

  task automatic do_add(input string tag, input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] exp_out, input logic exp_ovf);
    add_start = 1'b1;
    add_in1   = '0;
    add_in2   = '0;
    #1;
    check({tag, "_done_pre"}, 64'(add_done), 64'd0);
    step;
    add_start = 1'b0;
    add_in1   = a;
    add_in2   = b;
    #1;
    check({tag, "_done"}, 64'(add_done), 64'd1);
    check({tag, "_out"},  64'(add_out),  64'(exp_out));
    check({tag, "_ovf"},  64'(add_ovf),  64'(exp_ovf));
    step;
    check({tag, "_done_post"}, 64'(add_done), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    add_start  = 1'b0;
    add_in1    = '0;
    add_in2    = '0;
    char_start = 1'b0;
    char_in    = '0;
    repeat (3) step;
    check("rst_add_done",  64'(add_done),  64'd0);
    check("rst_char_busy", 64'(char_busy), 64'd0);
    check("rst_char_done", 64'(char_done), 64'd0);
    check("rst_char_out",  64'(char_out),  64'd0);
    reset = 1'b0;
    step;

    do_add("add_pp",    sm(0, 30'd5),          sm(0, 30'd7), sm(0, 30'd12), 1'b0);
    do_add("add_ovf_p", sm(0, 30'h3FFF_FFFF),  sm(0, 30'd1), sm(0, 30'd0),  1'b1);
    do_add("add_ovf_n", sm(1, 30'h3FFF_FFFF),  sm(1, 30'd1), sm(1, 30'd0),  1'b1);
    do_add("add_pn",    sm(0, 30'd5),          sm(1, 30'd7), sm(1, 30'd2),  1'b0);
    do_add("add_np",    sm(1, 30'd9),          sm(0, 30'd4), sm(1, 30'd5),  1'b0);
    do_add("add_zero",  sm(1, 30'd5),          sm(0, 30'd5), sm(1, 30'd0),  1'b0);
    do_add("add_negz",  sm(1, 30'd0),          sm(0, 30'd3), sm(0, 30'd3),  1'b0);

    // CHAR 12345 started together with an ADD
    char_in    = 30'd12345;
    char_start = 1'b1;
    add_start  = 1'b1;
    step;
    n          = 1;
    char_start = 1'b0;
    add_start  = 1'b0;
    add_in1    = sm(0, 30'd100);
    add_in2    = sm(1, 30'd1);
    #1;
    check("conc_add_done", 64'(add_done),  64'd1);
    check("conc_add_out",  64'(add_out),   64'(sm(0, 30'd99)));
    check("c1_busy",       64'(char_busy), 64'd1);
    while (!char_done && n < 100) begin
      step;
      n++;
    end
    check("c1_latency", 64'(n),         64'd31);
    check("c1_busy_end", 64'(char_busy), 64'd0);
    check("c1_out", 64'(char_out),
          64'({6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35}));
    step;
    check("c1_done_pulse", 64'(char_done), 64'd0);
    check("c1_out_hold", 64'(char_out),
          64'({6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35}));

    // CHAR max value, with a second start while busy
    char_in    = 30'd1073741823;
    char_start = 1'b1;
    step;
    n = 1;
    char_start = 1'b0;
    while (!char_done && n < 100) begin
      if (n == 5) begin
        char_in    = 30'd12345;
        char_start = 1'b1;
      end else begin
        char_start = 1'b0;
      end
      step;
      n++;
    end
    char_start = 1'b0;
    check("c2_latency", 64'(n), 64'd31);
    check("c2_out", 64'(char_out),
          64'({6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33}));
    extra = 0;
    repeat (40) begin
      step;
      if (char_done) extra++;
    end
    check("c2_ignored_start", 64'(extra), 64'd0);
    check("c2_idle", 64'(char_busy), 64'd0);

    // Reset ten cycles into a CHAR, with an ADD request during reset
    char_in    = 30'd999;
    char_start = 1'b1;
    step;
    char_start = 1'b0;
    repeat (9) step;
    check("c3_busy_before", 64'(char_busy), 64'd1);
    reset     = 1'b1;
    add_start = 1'b1;
    step;
    add_start = 1'b0;
    check("rst_mid_add_done", 64'(add_done),  64'd0);
    check("rst_mid_busy",     64'(char_busy), 64'd0);
    check("rst_mid_out",      64'(char_out),  64'd0);
    step;
    reset = 1'b0;
    check("rst_mid_add_ign", 64'(add_done), 64'd0);
    do_add("add_after_rst", sm(0, 30'd20), sm(1, 30'd3), sm(0, 30'd17), 1'b0);
    extra = 0;
    repeat (40) begin
      step;
      if (char_done) extra++;
    end
    check("c3_no_done",  64'(extra),     64'd0);
    check("c3_out_zero", 64'(char_out),  64'd0);
    check("c3_idle",     64'(char_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
